// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: arbitrates trap sources, records cause/EPC and
// drives the CP0 strobes, PC redirect and pipeline stall.
module exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        int_req,
  input  logic        eret_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] status_in,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        redirect,
  output logic        stall,
  output logic        int_ack,
  output logic [7:0]  exc_count
);

  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_SYS = 5'd8;
  localparam logic [4:0] CAUSE_BRK = 5'd9;
  localparam logic [4:0] CAUSE_TEQ = 5'd13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    ERET_S = 2'd2,
    REDIR  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        int_pend;
  logic        int_taken;
  logic        gie;
  logic        sys_ok;
  logic        brk_ok;
  logic        teq_ok;
  logic        int_ok;
  logic        any_ok;
  logic        is_idle;
  logic        take_exc;
  logic        take_eret;
  logic        take_int;
  logic [4:0]  cause_sel;

  // A source is eligible only when both its own enable and the global enable are set.
  always_comb begin
    gie       = status_in[0];
    sys_ok    = syscall_req & status_in[1] & gie;
    brk_ok    = break_req & status_in[2] & gie;
    teq_ok    = teq_req & status_in[3] & gie;
    int_ok    = (int_pend | int_req) & status_in[4] & gie;
    any_ok    = sys_ok | brk_ok | teq_ok | int_ok;
    is_idle   = (state == IDLE);
    take_exc  = is_idle & any_ok;
    take_eret = is_idle & eret_req & ~any_ok;
    take_int  = take_exc & ~sys_ok & ~brk_ok & ~teq_ok;
    if (sys_ok) begin
      cause_sel = CAUSE_SYS;
    end else if (brk_ok) begin
      cause_sel = CAUSE_BRK;
    end else if (teq_ok) begin
      cause_sel = CAUSE_TEQ;
    end else begin
      cause_sel = CAUSE_INT;
    end
  end

  always_comb begin
    state_nxt = state;
    exception = 1'b0;
    eret      = 1'b0;
    redirect  = 1'b0;
    int_ack   = 1'b0;
    stall     = 1'b1;
    case (state)
      IDLE: begin
        stall = take_exc | take_eret;
        if (take_exc) begin
          state_nxt = ENTER;
        end else if (take_eret) begin
          state_nxt = ERET_S;
        end
      end
      ENTER: begin
        exception = 1'b1;
        int_ack   = int_taken;
        state_nxt = REDIR;
      end
      ERET_S: begin
        eret      = 1'b1;
        state_nxt = REDIR;
      end
      REDIR: begin
        redirect  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A pending interrupt survives everything except its own acceptance or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_pend  <= 1'b0;
      int_taken <= 1'b0;
      cause     <= 5'd0;
      epc       <= 32'd0;
      exc_count <= 8'd0;
    end else begin
      state <= state_nxt;
      if (take_int) begin
        int_pend <= 1'b0;
      end else if (int_req) begin
        int_pend <= 1'b1;
      end
      if (take_exc) begin
        cause     <= cause_sel;
        epc       <= pc_in;
        int_taken <= take_int;
      end
      if (state == ENTER) begin
        exc_count <= exc_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected strobes, a monitor
// checks each exception/eret strobe against the queue.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        syscall_req;
  logic        break_req;
  logic        teq_req;
  logic        int_req;
  logic        eret_req;
  logic [31:0] pc_in;
  logic [31:0] status_in;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic        redirect;
  logic        stall;
  logic        int_ack;
  logic [7:0]  exc_count;

  typedef struct {
    logic        is_eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        int_ack;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] exp_cnt;

  exc_ctrl dut (
    .clk(clk),
    .rst(rst),
    .syscall_req(syscall_req),
    .break_req(break_req),
    .teq_req(teq_req),
    .int_req(int_req),
    .eret_req(eret_req),
    .pc_in(pc_in),
    .status_in(status_in),
    .exception(exception),
    .eret(eret),
    .cause(cause),
    .epc(epc),
    .redirect(redirect),
    .stall(stall),
    .int_ack(int_ack),
    .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic sys, input logic brk, input logic teq, input logic intr,
                               input logic er, input logic [31:0] pc, input logic [31:0] st);
    syscall_req = sys;
    break_req   = brk;
    teq_req     = teq;
    int_req     = intr;
    eret_req    = er;
    pc_in       = pc;
    status_in   = st;
  endtask

  // Issue a request at an IDLE negedge, follow it through ENTER and return in REDIR.
  task automatic runException(input logic sys, input logic brk, input logic teq, input logic intr,
                              input logic er, input logic [31:0] pc, input logic [31:0] st,
                              input logic [4:0] exp_cause, input logic exp_ack);
    @(negedge clk);
    applyStimulus(sys, brk, teq, intr, er, pc, st);
    exp_q.push_back('{1'b0, exp_cause, pc, exp_ack});
    #1 checkOutput("stall_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    checkOutput("stall_enter", {31'd0, stall}, 32'd1);
    checkOutput("no_eret_in_enter", {31'd0, eret}, 32'd0);
    checkOutput("no_redirect_in_enter", {31'd0, redirect}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc, st);
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    checkOutput("redirect_redir", {31'd0, redirect}, 32'd1);
    checkOutput("stall_redir", {31'd0, stall}, 32'd1);
    checkOutput("exc_count", {24'd0, exc_count}, {24'd0, exp_cnt});
  endtask

  always @(negedge clk) begin
    if (exception || eret) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_strobe: got exception=%b eret=%b, expected none at %0t",
                 exception, eret, $time);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("strobe_exception", {31'd0, exception}, {31'd0, !mon_e.is_eret});
        checkOutput("strobe_eret", {31'd0, eret}, {31'd0, mon_e.is_eret});
        checkOutput("strobe_int_ack", {31'd0, int_ack}, {31'd0, mon_e.int_ack});
        if (!mon_e.is_eret) begin
          checkOutput("strobe_cause", {27'd0, cause}, {27'd0, mon_e.cause});
          checkOutput("strobe_epc", epc, mon_e.epc);
        end
      end
    end else if (int_ack) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL stray_int_ack: got 1, expected 0 at %0t", $time);
    end
  end

  initial begin
    exp_cnt = 8'd0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_exception", {31'd0, exception}, 32'd0);
    checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_cause", {27'd0, cause}, 32'd0);
    checkOutput("rst_epc", epc, 32'd0);
    checkOutput("rst_exc_count", {24'd0, exc_count}, 32'd0);
    rst = 1'b0;

    // Basic syscall entry
    runException(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 32'h3, 5'd8, 1'b0);
    @(negedge clk);
    checkOutput("stall_back_idle", {31'd0, stall}, 32'd0);
    checkOutput("redirect_back_idle", {31'd0, redirect}, 32'd0);
    checkOutput("exc_count_one", {24'd0, exc_count}, 32'd1);
    checkOutput("cause_hold", {27'd0, cause}, 32'd8);

    // Ineligible syscall (global on, syscall enable off) is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h50, 32'h1);
    repeat (3) begin
      #1 checkOutput("stall_inelig_sys", {31'd0, stall}, 32'd0);
      @(negedge clk);
    end

    // Interrupt pulse while disabled stays pending, taken once enabled
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1);
    #1 checkOutput("stall_int_disabled", {31'd0, stall}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_int_pending", {31'd0, stall}, 32'd0);
    end
    runException(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h11, 5'd0, 1'b1);
    @(negedge clk);
    checkOutput("int_pend_cleared", {31'd0, stall}, 32'd0);

    // Syscall beats teq and interrupt; interrupt follows from pending
    runException(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1F, 5'd8, 1'b0);
    pc_in = 32'h204;
    exp_q.push_back('{1'b0, 5'd0, 32'h204, 1'b1});
    @(negedge clk);
    checkOutput("stall_pending_int", {31'd0, stall}, 32'd1);
    checkOutput("cause_before_next", {27'd0, cause}, 32'd8);
    @(negedge clk);
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    checkOutput("redirect_pending_int", {31'd0, redirect}, 32'd1);
    checkOutput("exc_count_pending_int", {24'd0, exc_count}, {24'd0, exp_cnt});
    @(negedge clk);
    checkOutput("stall_after_int", {31'd0, stall}, 32'd0);

    // ERET with all enables off
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h0);
    exp_q.push_back('{1'b1, 5'd0, 32'd0, 1'b0});
    #1 checkOutput("stall_eret_accept", {31'd0, stall}, 32'd1);
    @(negedge clk);
    checkOutput("no_exception_in_eret", {31'd0, exception}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    @(negedge clk);
    checkOutput("redirect_eret", {31'd0, redirect}, 32'd1);
    checkOutput("exc_count_eret", {24'd0, exc_count}, {24'd0, exp_cnt});
    @(negedge clk);
    checkOutput("stall_after_eret", {31'd0, stall}, 32'd0);

    // Eligible break wins over simultaneous ERET
    runException(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h304, 32'h5, 5'd9, 1'b0);

    // Reset clears a pending interrupt
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 8'd0;
    status_in = 32'h11;
    repeat (3) begin
      #1 checkOutput("stall_pend_reset", {31'd0, stall}, 32'd0);
      @(negedge clk);
    end

    // Reset in ENTER aborts the sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h3);
    exp_q.push_back('{1'b0, 5'd8, 32'h500, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h3);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_enter_exception", {31'd0, exception}, 32'd0);
    checkOutput("rst_enter_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_enter_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_enter_cause", {27'd0, cause}, 32'd0);
    checkOutput("rst_enter_epc", epc, 32'd0);
    checkOutput("rst_enter_exc_count", {24'd0, exc_count}, 32'd0);
    @(negedge clk);
    checkOutput("rst_enter_no_redirect", {31'd0, redirect}, 32'd0);

    // Reset wins over a same-cycle eligible request
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h3);
    #1 checkOutput("rst_prio_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    checkOutput("rst_prio_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("rst_prio_count", {24'd0, exc_count}, 32'd0);

    // 256 back-to-back exceptions wrap the counter
    for (int i = 0; i < 256; i++) begin
      runException(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000 + i * 4, 32'h3, 5'd8, 1'b0);
    end
    @(negedge clk);
    checkOutput("exc_count_wrap", {24'd0, exc_count}, 32'd0);
    checkOutput("stall_final", {31'd0, stall}, 32'd0);

    repeat (2) @(negedge clk);
    checkOutput("queue_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
